// File: rtl/output_seq_pkg.sv
// Shared constants and state encoding for the output register file sequencer.
package output_seq_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;
    localparam int PTR_W  = IDX_W + 1;

    // Pointer-width constants; DEPTH needs the extra pointer bit to be representable.
    localparam logic [PTR_W-1:0] DEPTH   = {1'b1, {IDX_W{1'b0}}};
    localparam logic [PTR_W-1:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A configured length of zero selects a full-depth batch.
    function automatic logic [PTR_W-1:0] batch_len(input logic [PTR_W-1:0] cfg);
        return (cfg == '0) ? DEPTH : cfg;
    endfunction

endpackage

// File: rtl/output_seq_if.sv
// Control, result stream, register file port and drain stream of the sequencer.
interface output_seq_if;
    import output_seq_pkg::*;

    logic              start;
    logic [PTR_W-1:0]  cfg_count;
    logic              flush;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    logic [IDX_W-1:0]  reg_index;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_we;
    logic [DATA_W-1:0] reg_rdata;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              out_ready;

    logic              busy;
    logic              done;

    // Sequencer side.
    modport master (
        input  start, cfg_count, flush,
        input  res_valid, res_data,
        output res_ready,
        output reg_index, reg_wdata, reg_we,
        input  reg_rdata,
        output out_valid, out_data, out_index, out_last,
        input  out_ready,
        output busy, done
    );

    // Surrounding logic: accumulator, register file and drain consumer.
    modport slave (
        output start, cfg_count, flush,
        output res_valid, res_data,
        input  res_ready,
        input  reg_index, reg_wdata, reg_we,
        output reg_rdata,
        input  out_valid, out_data, out_index, out_last,
        output out_ready,
        input  busy, done
    );

endinterface

// File: rtl/output_sequencer.sv
// Fills the output register file from the accumulator result stream starting
// at index 0, then drains the same indices to the downstream stream.
//
// state | meaning
// IDLE  | waiting for start; register file port parked at index 0
// FILL  | accepting results, writing each to index wr_ptr
// DRAIN | presenting register file word at rd_ptr until the last one is taken
module output_sequencer
    import output_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    output_seq_if.master bus
);

    state_t            state, state_n;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0]  len, len_n;
    logic [PTR_W-1:0]  len_last;
    logic              done_q, done_n;

    logic              res_hs;
    logic              res_ready;
    logic              reg_we;
    logic [IDX_W-1:0]  reg_index;
    logic              out_valid;
    logic              out_last;
    logic [IDX_W-1:0]  out_index;

    assign len_last = len - PTR_ONE;

    // State, pointer, length and done-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            len    <= len_n;
            done_q <= done_n;
        end
    end

    // Next-state, pointer updates and combinational port outputs.
    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        len_n     = len;
        done_n    = 1'b0;
        res_hs    = 1'b0;
        res_ready = 1'b0;
        reg_we    = 1'b0;
        reg_index = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_index = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    len_n    = batch_len(bus.cfg_count);
                    wr_ptr_n = '0;
                    rd_ptr_n = '0;
                    state_n  = FILL;
                end
            end

            FILL: begin
                res_ready = 1'b1;
                reg_index = wr_ptr[IDX_W-1:0];
                res_hs    = bus.res_valid;
                reg_we    = res_hs;
                if (res_hs) begin
                    wr_ptr_n = wr_ptr + PTR_ONE;
                end
                // A flush keeps a result accepted in the same cycle.
                if (bus.flush) begin
                    len_n = wr_ptr + {{IDX_W{1'b0}}, res_hs};
                    if (len_n == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (res_hs && (wr_ptr == len_last)) begin
                    state_n = DRAIN;
                end
            end

            DRAIN: begin
                reg_index = rd_ptr[IDX_W-1:0];
                out_valid = 1'b1;
                out_index = rd_ptr[IDX_W-1:0];
                out_last  = (rd_ptr == len_last);
                if (bus.out_ready) begin
                    rd_ptr_n = rd_ptr + PTR_ONE;
                    if (out_last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.res_ready = res_ready;
    assign bus.reg_index = reg_index;
    assign bus.reg_wdata = bus.res_data;
    assign bus.reg_we    = reg_we;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = bus.reg_rdata;
    assign bus.out_index = out_index;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

    // Pointers stay within the latched batch length.
    a_wr_bound: assert property (@(posedge clk) disable iff (rst)
        (state == FILL) |-> (wr_ptr < len));
    a_rd_bound: assert property (@(posedge clk) disable iff (rst)
        (state == DRAIN) |-> (rd_ptr < len));
    // The done pulse always lands in IDLE.
    a_done_idle: assert property (@(posedge clk) disable iff (rst)
        done_q |-> (state == IDLE));

endmodule

// File: tb/tb_output_sequencer.sv
module tb_output_sequencer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    output_seq_if bus ();

    output_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file the sequencer drives: synchronous write, combinational read.
    logic [15:0] mem [32];
    always @(posedge clk) begin
        if (bus.reg_we) mem[bus.reg_index] <= bus.reg_wdata;
    end
    assign bus.reg_rdata = mem[bus.reg_index];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] cnt);
        bus.start     = 1'b1;
        bus.cfg_count = cnt;
        tick();
        bus.start     = 1'b0;
        bus.cfg_count = 6'd0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst = 1'b1;
        bus.res_data = 16'h1234;
        #2;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b exp 0", bus.busy); end
        vectors++; if (bus.res_ready !== 1'b0) begin miscompares++; $display("FAIL rst_res_ready got %0b exp 0", bus.res_ready); end
        vectors++; if (bus.reg_we !== 1'b0 || bus.reg_index !== 5'd0) begin miscompares++; $display("FAIL rst_reg got we=%0b idx=%0d exp 0/0", bus.reg_we, bus.reg_index); end
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_index !== 5'd0) begin miscompares++; $display("FAIL rst_out got v=%0b l=%0b i=%0d exp 0", bus.out_valid, bus.out_last, bus.out_index); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0b exp 0", bus.done); end
        vectors++; if (bus.reg_wdata !== 16'h1234) begin miscompares++; $display("FAIL rst_wdata got %h exp 1234", bus.reg_wdata); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Abort mid-FILL after five writes.
        do_start(6'd8);
        for (int i = 0; i < 5; i++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0300 + 16'(i);
            tick();
        end
        bus.res_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.res_ready !== 1'b0 || bus.reg_we !== 1'b0) begin miscompares++; $display("FAIL midrst_ctl got busy=%0b rdy=%0b we=%0b exp 0", bus.busy, bus.res_ready, bus.reg_we); end
        vectors++; if (bus.reg_index !== 5'd0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_out got idx=%0d v=%0b done=%0b exp 0", bus.reg_index, bus.out_valid, bus.done); end
        bus.res_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_nodone got %0b exp 0", bus.done); end
        // New batch of three restarts at index 0.
        do_start(6'd3);
        for (int i = 0; i < 3; i++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0400 + 16'(i);
            #1;
            vectors++; if (bus.reg_we !== 1'b1 || bus.reg_index !== 5'(i)) begin miscompares++; $display("FAIL restart_wr got we=%0b idx=%0d exp 1/%0d", bus.reg_we, bus.reg_index, i); end
            tick();
        end
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 16'h0400 + 16'(i);
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_last !== (i == 2)) begin miscompares++; $display("FAIL restart_rd got v=%0b d=%h l=%0b exp 1/%h/%0b", bus.out_valid, bus.out_data, bus.out_last, exp, (i == 2)); end
            tick();
        end
        bus.out_ready = 1'b0;
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL restart_done got done=%0b busy=%0b exp 1/0", bus.done, bus.busy); end
        tick();
    endtask

    task automatic test_full_batch();
        logic [15:0] exp;
        do_start(6'd0);                     // cycle 0
        for (int i = 0; i < 32; i++) begin  // cycles 1..32
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0100 + 16'(i);
            #1;
            vectors++; if (bus.res_ready !== 1'b1 || bus.reg_we !== 1'b1 || bus.reg_index !== 5'(i) || bus.busy !== 1'b1) begin miscompares++; $display("FAIL full_fill[%0d] got rdy=%0b we=%0b idx=%0d busy=%0b", i, bus.res_ready, bus.reg_we, bus.reg_index, bus.busy); end
            tick();
        end
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin  // cycles 33..64
            exp = 16'h0100 + 16'(i);
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_index !== 5'(i) || bus.out_last !== (i == 31) || bus.res_ready !== 1'b0) begin miscompares++; $display("FAIL full_drain[%0d] got v=%0b d=%h i=%0d l=%0b exp d=%h", i, bus.out_valid, bus.out_data, bus.out_index, bus.out_last, exp); end
            tick();
        end
        bus.out_ready = 1'b0;
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL full_done65 got done=%0b busy=%0b v=%0b exp 1/0/0", bus.done, bus.busy, bus.out_valid); end
        tick();
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL full_done66 got %0b exp 0", bus.done); end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat;
        logic [15:0] exp;
        int k;
        pat = 4'b1001;
        do_start(6'd4);
        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0200 + 16'(i);
            tick();
        end
        bus.res_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            bus.out_ready = pat[3 - (c % 4)];
            exp = 16'h0200 + 16'(k);
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_index !== 5'(k) || bus.out_data !== exp || bus.out_last !== (k == 3)) begin miscompares++; $display("FAIL bp_word c=%0d got v=%0b i=%0d d=%h l=%0b exp i=%0d d=%h", c, bus.out_valid, bus.out_index, bus.out_data, bus.out_last, k, exp); end
            if (bus.out_ready) k++;
            tick();
        end
        bus.out_ready = 1'b0;
        vectors++; if (k !== 4) begin miscompares++; $display("FAIL bp_count got %0d exp 4", k); end
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL bp_done got done=%0b busy=%0b exp 1/0", bus.done, bus.busy); end
        tick();
    endtask

    task automatic test_flush_same_cycle();
        logic [15:0] exp;
        do_start(6'd10);
        for (int i = 0; i < 3; i++) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0500 + 16'(i);
            bus.flush     = (i == 2);
            #1;
            vectors++; if (bus.reg_we !== 1'b1 || bus.reg_index !== 5'(i)) begin miscompares++; $display("FAIL flush_wr[%0d] got we=%0b idx=%0d", i, bus.reg_we, bus.reg_index); end
            tick();
        end
        bus.res_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 16'h0500 + 16'(i);
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.out_index !== 5'(i) || bus.out_last !== (i == 2)) begin miscompares++; $display("FAIL flush_drain[%0d] got v=%0b d=%h i=%0d l=%0b exp d=%h", i, bus.out_valid, bus.out_data, bus.out_index, bus.out_last, exp); end
            tick();
        end
        bus.out_ready = 1'b0;
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_done got done=%0b busy=%0b exp 1/0", bus.done, bus.busy); end
        tick();
    endtask

    task automatic test_empty_flush();
        do_start(6'd5);
        bus.flush = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b1 || bus.reg_we !== 1'b0) begin miscompares++; $display("FAIL eflush_fill got busy=%0b we=%0b exp 1/0", bus.busy, bus.reg_we); end
        tick();
        bus.flush = 1'b0;
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL eflush_done got done=%0b busy=%0b v=%0b exp 1/0/0", bus.done, bus.busy, bus.out_valid); end
        tick();
        vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL eflush_after got done=%0b busy=%0b exp 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_ignored_controls();
        logic [15:0] exp;
        do_start(6'd2);
        for (int i = 0; i < 2; i++) begin
            bus.start     = 1'b1;
            bus.cfg_count = 6'd7;
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0600 + 16'(i);
            #1;
            vectors++; if (bus.reg_index !== 5'(i) || bus.reg_we !== 1'b1) begin miscompares++; $display("FAIL ign_fill[%0d] got idx=%0d we=%0b", i, bus.reg_index, bus.reg_we); end
            tick();
        end
        bus.res_valid = 1'b0;
        // Stalled DRAIN cycle with flush and start asserted.
        bus.flush     = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd0 || bus.out_data !== 16'h0600 || bus.out_last !== 1'b0) begin miscompares++; $display("FAIL ign_stall got v=%0b i=%0d d=%h l=%0b exp 1/0/0600/0", bus.out_valid, bus.out_index, bus.out_data, bus.out_last); end
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp = 16'h0600 + 16'(i);
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_index !== 5'(i) || bus.out_data !== exp || bus.out_last !== (i == 1)) begin miscompares++; $display("FAIL ign_drain[%0d] got v=%0b i=%0d d=%h l=%0b exp d=%h", i, bus.out_valid, bus.out_index, bus.out_data, bus.out_last, exp); end
            tick();
        end
        bus.start     = 1'b0;
        bus.cfg_count = 6'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL ign_done got done=%0b busy=%0b exp 1/0", bus.done, bus.busy); end
        tick();
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL ign_idle got busy=%0b done=%0b exp 0/0", bus.busy, bus.done); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_count = 6'd0;
        bus.flush     = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = 16'h0000;
        bus.out_ready = 1'b0;

        test_reset();
        test_full_batch();
        test_backpressure();
        test_flush_same_cycle();
        test_empty_flush();
        test_ignored_controls();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
